// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_wires
// Types and helpers private to fetch_stage: FSM state encoding, the complete
// register record (pc, state, decode-facing output registers) and its reset
// value, plus small instruction-format helpers.
// -----------------------------------------------------------------------------
package fetch_stage_wires;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } fetch_state_type;

   typedef struct packed {
      logic [31:0]     pc;
      fetch_state_type state;
      logic            instr_valid;
      logic [31:0]     instr_pc;
      logic [31:0]     instr;
      logic            instr_comp;
      logic [31:0]     instr_npc;
   } reg_type;

   // Reset record: everything zero except pc, which starts at the halfword-
   // aligned reset vector.
   function automatic reg_type init_reg(input logic [31:0] reset_vector);
      reg_type res;
      res       = '0;
      res.pc    = reset_vector & ~32'h1;
      res.state = RESET;
      return res;
   endfunction

   // Any encoding other than 2'b11 in the low two bits is a 16-bit instruction.
   function automatic logic is_compressed(input logic [31:0] rdata);
      return (rdata[1:0] != 2'b11);
   endfunction

   // Compressed instructions are presented zero-extended.
   function automatic logic [31:0] align_instr(input logic [31:0] rdata);
      return is_compressed(rdata) ? {16'h0000, rdata[15:0]} : rdata;
   endfunction

   function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic comp);
      return pc + (comp ? 32'd2 : 32'd4);
   endfunction

endpackage

// File: rtl/wires_pkg.sv
// -----------------------------------------------------------------------------
// wires
// Shared memory-port bundles used between the core front end and the fetch
// buffer.
//   mem_in_type  : request  (valid, fence, instr, addr, wdata, wstrb)
//   mem_out_type : response (ready, rdata), combinational in the request cycle
// -----------------------------------------------------------------------------
package wires;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_fence;
      logic        mem_instr;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic [31:0] mem_rdata;
   } mem_out_type;

endpackage

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage. Owns the program counter, issues one request per
// cycle to the fetch buffer, registers the returned 16/32-bit instruction and
// presents it to decode together with its PC and the following PC. Handles
// redirects, fence.i and decode back-pressure.
//
// Ports
//   clk             in   clock
//   rst             in   synchronous reset, active low
//   redirect_valid  in   branch/trap redirect
//   redirect_addr   in   redirect / fence restart target (bit 0 ignored)
//   fence_valid     in   fence.i request
//   stall           in   decode cannot accept the presented instruction
//   fetchbuffer_out in   fetch buffer response (ready, rdata)
//   fetchbuffer_in  out  fetch buffer request (valid, fence, addr, ...)
//   instr_valid     out  presented instruction valid
//   instr_pc        out  PC of presented instruction
//   instr           out  instruction (compressed form zero-extended)
//   instr_comp      out  presented instruction is 16-bit
//   instr_npc       out  PC following the presented instruction
// -----------------------------------------------------------------------------
module fetch_stage
   import wires::*;
   import fetch_stage_wires::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   input  logic        fence_valid,
   input  logic        stall,
   input  mem_out_type fetchbuffer_out,
   output mem_in_type  fetchbuffer_in,
   output logic        instr_valid,
   output logic [31:0] instr_pc,
   output logic [31:0] instr,
   output logic        instr_comp,
   output logic [31:0] instr_npc
);

   reg_type    r;
   reg_type    rin;
   reg_type    v;
   mem_in_type w_req;

   always_comb begin
      v     = r;
      w_req = '0;
      // The address always comes straight from the pc register; only the
      // valid/fence qualifiers react to this cycle's control inputs.
      w_req.mem_instr = 1'b1;
      w_req.mem_addr  = r.pc;

      if (!rst) begin
         v = init_reg(RESET_VECTOR);
      end else if (fence_valid) begin
         // The fence is sent as a request of its own; whatever data comes back
         // in this cycle is discarded along with the presented instruction.
         w_req.mem_valid = 1'b1;
         w_req.mem_fence = 1'b1;
         v.state         = FLUSH;
         v.pc            = redirect_addr & ~32'h1;
         v.instr_valid   = 1'b0;
      end else if (redirect_valid) begin
         v.state       = FLUSH;
         v.pc          = redirect_addr & ~32'h1;
         v.instr_valid = 1'b0;
      end else begin
         case (r.state)
            RESET: begin
               v.state = FETCH;
            end
            FETCH, HOLD, FLUSH: begin
               // An empty output register never blocks, even under stall.
               if (r.instr_valid && stall) begin
                  v.state = HOLD;
               end else begin
                  w_req.mem_valid = 1'b1;
                  v.state         = FETCH;
                  if (fetchbuffer_out.mem_ready) begin
                     v.instr_valid = 1'b1;
                     v.instr_pc    = r.pc;
                     v.instr       = align_instr(fetchbuffer_out.mem_rdata);
                     v.instr_comp  = is_compressed(fetchbuffer_out.mem_rdata);
                     v.instr_npc   = next_pc(r.pc, is_compressed(fetchbuffer_out.mem_rdata));
                     v.pc          = next_pc(r.pc, is_compressed(fetchbuffer_out.mem_rdata));
                  end else begin
                     // Not ready (e.g. fence invalidation in progress): retry same pc.
                     v.instr_valid = 1'b0;
                  end
               end
            end
            default: begin
               v.state = RESET;
            end
         endcase
      end

      rin = v;
   end

   always_ff @(posedge clk) begin
      r <= rin;
   end

   assign fetchbuffer_in = w_req;
   assign instr_valid    = r.instr_valid;
   assign instr_pc       = r.instr_pc;
   assign instr          = r.instr;
   assign instr_comp     = r.instr_comp;
   assign instr_npc      = r.instr_npc;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Scoreboard bench for fetch_stage. The driver applies one cycle of stimulus at
// a time, advances a behavioural model of the fetch rules and queues the
// expected request for that cycle and any instruction it should deliver. A
// monitor on the falling edge compares requests every cycle and presented
// instructions whenever instr_valid is high.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
   import wires::*;

   localparam logic [31:0] RV = 32'h80000000;

   typedef struct {
      logic        v;
      logic        f;
      logic [31:0] a;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
      logic        comp;
      logic [31:0] npc;
   } out_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_addr = '0;
   logic        fence_valid = 1'b0;
   logic        stall = 1'b0;
   mem_out_type fb_out = '0;
   mem_in_type  fb_in;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic [31:0] instr;
   logic        instr_comp;
   logic [31:0] instr_npc;

   fetch_stage #(.RESET_VECTOR(RV)) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_addr   (redirect_addr),
      .fence_valid     (fence_valid),
      .stall           (stall),
      .fetchbuffer_out (fb_out),
      .fetchbuffer_in  (fb_in),
      .instr_valid     (instr_valid),
      .instr_pc        (instr_pc),
      .instr           (instr),
      .instr_comp      (instr_comp),
      .instr_npc       (instr_npc)
   );

   always #5 clk = ~clk;

   req_t        req_q[$];
   out_t        out_q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   bit          started = 1'b0;

   // Model state: next fetch address, whether decode currently sees an
   // instruction, and whether the first cycle out of reset is still pending.
   logic [31:0] m_pc = RV;
   bit          m_ov = 1'b0;
   bit          m_idle = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of stimulus, advance the model, then step past the edge.
   task automatic drive(input bit r_n, input bit ready, input logic [31:0] rdata,
                        input bit st, input bit rd, input bit fe, input logic [31:0] ra);
      req_t q;
      out_t o;
      rst               = r_n;
      fb_out.mem_ready  = ready;
      fb_out.mem_rdata  = rdata;
      stall             = st;
      redirect_valid    = rd;
      fence_valid       = fe;
      redirect_addr     = ra;
      q = '{v: 1'b0, f: 1'b0, a: 32'h0};
      if (!r_n) begin
         m_pc = RV; m_ov = 1'b0; m_idle = 1'b1;
      end else if (fe) begin
         q = '{v: 1'b1, f: 1'b1, a: m_pc};
         m_pc = {ra[31:1], 1'b0}; m_ov = 1'b0; m_idle = 1'b0;
      end else if (rd) begin
         m_pc = {ra[31:1], 1'b0}; m_ov = 1'b0; m_idle = 1'b0;
      end else if (m_idle) begin
         m_idle = 1'b0;
      end else if (m_ov && st) begin
         // decode is holding the current instruction; nothing requested
      end else begin
         q = '{v: 1'b1, f: 1'b0, a: m_pc};
         if (ready) begin
            o.pc   = m_pc;
            o.comp = (rdata[1:0] != 2'b11);
            o.ins  = o.comp ? (rdata & 32'h0000FFFF) : rdata;
            o.npc  = m_pc + (o.comp ? 32'd2 : 32'd4);
            out_q.push_back(o);
            m_pc = o.npc;
            m_ov = 1'b1;
         end else begin
            m_ov = 1'b0;
         end
      end
      req_q.push_back(q);
      started = 1'b1;
      @(posedge clk);
      #1;
   endtask

   req_t me;
   out_t mo;

   always @(negedge clk) begin
      if (started) begin
         if (req_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL req_queue: got empty queue required an entry (t=%0t)", $time);
         end else begin
            me = req_q.pop_front();
            check("mem_valid", 32'(fb_in.mem_valid), 32'(me.v));
            check("mem_fence", 32'(fb_in.mem_fence), 32'(me.f));
            if (me.v) begin
               check("mem_addr", fb_in.mem_addr, me.a);
               check("mem_instr", 32'(fb_in.mem_instr), 32'd1);
            end
         end
         if (rst && instr_valid) begin
            if (out_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL out_queue: got instr_valid=1 pc=%h required no instruction (t=%0t)", instr_pc, $time);
            end else begin
               mo = out_q[0];
               check("instr_pc", instr_pc, mo.pc);
               check("instr", instr, mo.ins);
               check("instr_comp", 32'(instr_comp), 32'(mo.comp));
               check("instr_npc", instr_npc, mo.npc);
               // Presented instruction leaves when decode takes it or a flush drops it.
               if (!stall || redirect_valid || fence_valid) void'(out_q.pop_front());
            end
         end
      end
   end

   logic [31:0] rd_word;
   logic [31:0] ra_word;

   initial begin
      @(posedge clk);
      #1;
      // Reset
      repeat (3) drive(1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 1'b0, 32'h0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instr_pc", instr_pc, 32'd0);
      check("rst_instr_npc", instr_npc, 32'd0);
      check("rst_instr", instr, 32'd0);

      // First fetch out of reset
      drive(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 32'h0);
      check("first_valid", 32'(instr_valid), 32'd1);
      check("first_pc", instr_pc, 32'h80000000);
      check("first_npc", instr_npc, 32'h80000004);
      drive(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 32'h0);

      // Mixed compressed / 32-bit stream from address 0
      drive(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 32'hBEEF4501, 1'b0, 1'b0, 1'b0, 32'h0);
      check("mix_pc0", instr_pc, 32'h0);
      check("mix_instr0", instr, 32'h00004501);
      check("mix_comp0", 32'(instr_comp), 32'd1);
      drive(1'b1, 1'b1, 32'h00A00093, 1'b0, 1'b0, 1'b0, 32'h0);
      check("mix_pc1", instr_pc, 32'h2);
      check("mix_comp1", 32'(instr_comp), 32'd0);
      drive(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 32'h0);
      check("mix_pc2", instr_pc, 32'h6);

      // Stall for three cycles while valid, then resume
      repeat (3) drive(1'b1, 1'b1, $urandom, 1'b1, 1'b0, 1'b0, 32'h0);
      check("stall_pc_held", instr_pc, 32'h6);
      repeat (2) drive(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 32'h0);

      // Redirect while held
      drive(1'b1, 1'b1, 32'h00000013, 1'b1, 1'b0, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 32'h00000013, 1'b1, 1'b1, 1'b0, 32'h00001003);
      check("hold_redir_valid", 32'(instr_valid), 32'd0);
      check("hold_redir_addr", fb_in.mem_addr, 32'h00001002);
      repeat (2) drive(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 32'h0);

      // fence.i followed by a long not-ready window
      drive(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b1, 32'h00000400);
      repeat (16) drive(1'b1, 1'b0, $urandom, 1'b0, 1'b0, 1'b0, 32'h0);
      check("fence_no_valid", 32'(instr_valid), 32'd0);
      check("fence_pc_held", fb_in.mem_addr, 32'h00000400);
      repeat (3) drive(1'b1, 1'b1, 32'h00A00093, 1'b0, 1'b0, 1'b0, 32'h0);

      // PC wrap at the top of the address space
      drive(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF);
      drive(1'b1, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h0);
      check("wrap_pc", instr_pc, 32'hFFFFFFFE);
      check("wrap_npc", instr_npc, 32'h0);
      check("wrap_next_addr", fb_in.mem_addr, 32'h0);
      drive(1'b1, 1'b1, 32'h00000013, 1'b0, 1'b0, 1'b0, 32'h0);

      // Randomised traffic
      for (int i = 0; i < 800; i++) begin
         rd_word = $urandom;
         ra_word = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 | ($urandom & 32'h7)) : $urandom;
         drive(1'b1, ($urandom_range(0, 4) != 0), rd_word, ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 29) == 0), ($urandom_range(0, 49) == 0), ra_word);
      end

      // Drain: let decode take the last instruction
      repeat (2) drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      started = 1'b0;
      check("out_queue_left", 32'(out_q.size()), 32'd0);
      check("req_queue_left", 32'(req_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
